i2c_target_regs: RTL and testbench

//  I2C target (responder) with an internal 8-bit register file, answering config sequences

---
 rtl/i2c_pkg.sv | 29 ++
 rtl/i2c_line_sync.sv | 60 ++++++
 rtl/i2c_target_regs.sv | 243 ++++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
`timescale 1ns/1ps
// Shared state encoding, bus level constants and defaults for the I2C target register bank.
package i2c_pkg;

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WRITE_DATA,
        WRITE_ACK,
        READ_DATA,
        READ_ACK,
        IGNORE
    } i2c_state_t;

    localparam logic        LVL_ACK              = 1'b0;
    localparam logic        LVL_NACK             = 1'b1;
    localparam logic [6:0]  DEFAULT_TARGET_ADDR  = 7'h39;
    localparam int unsigned DEFAULT_FILTER_DEPTH = 3;
    localparam int unsigned DEFAULT_REG_DEPTH    = 256;
    localparam logic [3:0]  BITS_PER_BYTE        = 4'd8;

    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] target);
        return addr_byte[7:1] == target;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
`timescale 1ns/1ps
// Conditions one bus line: two-flop synchroniser, FILTER_DEPTH-sample glitch filter,
// and single-cycle rise/fall pulses aligned with the filtered level.
module i2c_line_sync #(
    parameter int unsigned FILTER_DEPTH = 3
) (
    input  logic clock_25,
    input  logic reset,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    localparam int unsigned SETTLE_CYCLES = FILTER_DEPTH + 3;
    localparam int unsigned SETTLE_W      = $clog2(SETTLE_CYCLES + 1);

    logic [1:0]              r_sync;
    logic [FILTER_DEPTH-1:0] r_hist;
    logic [SETTLE_W-1:0]     r_settle;
    logic                    r_level;
    logic                    r_rise;
    logic                    r_fall;
    logic                    w_all_high;
    logic                    w_all_low;
    logic                    w_settled;

    assign w_all_high = &r_hist;
    assign w_all_low  = ~|r_hist;
    assign w_settled  = (r_settle == '0);

    // Edges stay masked until the history holds only post-reset samples, so leaving
    // reset in the middle of a transfer never fabricates a START or STOP.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            r_sync   <= 2'b11;
            r_hist   <= '1;
            r_settle <= SETTLE_W'(SETTLE_CYCLES);
            r_level  <= 1'b1;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_line};
            r_hist <= FILTER_DEPTH'({r_hist, r_sync[1]});
            if (!w_settled) begin
                r_settle <= r_settle - SETTLE_W'(1);
            end
            if (w_all_high || w_all_low) begin
                r_level <= w_all_high;
            end
            r_rise <= w_settled && w_all_high && !r_level;
            r_fall <= w_settled && w_all_low && r_level;
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/i2c_target_regs.sv
`timescale 1ns/1ps
// I2C target with an internal byte-wide register file. SCL/SDA are oversampled on clock_25,
// SDA is open-drain, and SCL is never stretched.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0]  TARGET_ADDR  = DEFAULT_TARGET_ADDR,
    parameter int unsigned FILTER_DEPTH = DEFAULT_FILTER_DEPTH,
    parameter int unsigned REG_DEPTH    = DEFAULT_REG_DEPTH
) (
    input  logic       clock_25,
    input  logic       reset,
    input  logic       i2c_serial_clock,
    inout  wire logic  i2c_serial_data,
    output logic       reg_write_strobe,
    output logic [7:0] reg_write_address,
    output logic [7:0] reg_write_data,
    output logic       busy
);

    localparam logic [7:0] PTR_MASK = 8'(REG_DEPTH - 1);

    i2c_state_t r_state;
    i2c_state_t w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic [7:0] r_ptr;
    logic [7:0] w_ptr_nxt;
    logic       r_sda_out;
    logic       w_sda_out_nxt;
    logic       r_busy;
    logic       w_busy_nxt;
    logic       r_rw;
    logic       w_rw_nxt;
    logic       r_mack;
    logic       w_mack_nxt;
    logic       w_wr_en;
    logic       r_strobe;
    logic [7:0] r_wr_addr;
    logic [7:0] r_wr_data;
    logic [7:0] r_mem [REG_DEPTH];

    logic       w_scl_lvl;
    logic       w_scl_rise;
    logic       w_scl_fall;
    logic       w_sda_lvl;
    logic       w_sda_rise;
    logic       w_sda_fall;
    logic       w_start;
    logic       w_stop;
    logic [7:0] w_byte_in;
    logic [7:0] w_rd_byte;
    logic [7:0] w_ptr_inc;

    i2c_line_sync #(.FILTER_DEPTH(FILTER_DEPTH)) u_scl_sync (
        .clock_25 (clock_25),
        .reset    (reset),
        .i_line   (i2c_serial_clock),
        .o_level  (w_scl_lvl),
        .o_rise   (w_scl_rise),
        .o_fall   (w_scl_fall)
    );

    i2c_line_sync #(.FILTER_DEPTH(FILTER_DEPTH)) u_sda_sync (
        .clock_25 (clock_25),
        .reset    (reset),
        .i_line   (i2c_serial_data),
        .o_level  (w_sda_lvl),
        .o_rise   (w_sda_rise),
        .o_fall   (w_sda_fall)
    );

    assign w_start   = w_sda_fall && w_scl_lvl;
    assign w_stop    = w_sda_rise && w_scl_lvl;
    assign w_byte_in = {r_shift[6:0], w_sda_lvl};
    assign w_rd_byte = r_mem[r_ptr];
    assign w_ptr_inc = (r_ptr + 8'd1) & PTR_MASK;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_shift_nxt   = r_shift;
        w_ptr_nxt     = r_ptr;
        w_sda_out_nxt = r_sda_out;
        w_busy_nxt    = r_busy;
        w_rw_nxt      = r_rw;
        w_mack_nxt    = r_mack;
        w_wr_en       = 1'b0;

        if (w_start) begin
            w_state_nxt   = ADDR;
            w_cnt_nxt     = '0;
            w_sda_out_nxt = LVL_NACK;
        end else if (w_stop) begin
            w_state_nxt   = IDLE;
            w_cnt_nxt     = '0;
            w_sda_out_nxt = LVL_NACK;
            w_busy_nxt    = 1'b0;
        end else begin
            unique case (r_state)
                IDLE, IGNORE: begin
                    w_sda_out_nxt = LVL_NACK;
                end
                ADDR, PTR, WRITE_DATA: begin
                    if (w_scl_rise && r_cnt < BITS_PER_BYTE) begin
                        w_shift_nxt = w_byte_in;
                        w_cnt_nxt   = r_cnt + 4'd1;
                        if (r_cnt == BITS_PER_BYTE - 4'd1) begin
                            if (r_state == PTR) begin
                                w_ptr_nxt = w_byte_in & PTR_MASK;
                            end else if (r_state == WRITE_DATA) begin
                                w_wr_en   = 1'b1;
                                w_ptr_nxt = w_ptr_inc;
                            end
                        end
                    end else if (w_scl_fall && r_cnt == BITS_PER_BYTE) begin
                        w_cnt_nxt = '0;
                        if (r_state == ADDR) begin
                            if (addr_match(r_shift, TARGET_ADDR)) begin
                                w_state_nxt   = ADDR_ACK;
                                w_sda_out_nxt = LVL_ACK;
                                w_busy_nxt    = 1'b1;
                                w_rw_nxt      = r_shift[0];
                            end else begin
                                w_state_nxt   = IGNORE;
                                w_sda_out_nxt = LVL_NACK;
                                w_busy_nxt    = 1'b0;
                            end
                        end else begin
                            w_state_nxt   = (r_state == PTR) ? PTR_ACK : WRITE_ACK;
                            w_sda_out_nxt = LVL_ACK;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (w_scl_fall) begin
                        w_cnt_nxt = '0;
                        if (r_rw) begin
                            w_state_nxt   = READ_DATA;
                            w_shift_nxt   = w_rd_byte;
                            w_sda_out_nxt = w_rd_byte[7];
                        end else begin
                            w_state_nxt   = PTR;
                            w_sda_out_nxt = LVL_NACK;
                        end
                    end
                end
                PTR_ACK, WRITE_ACK: begin
                    if (w_scl_fall) begin
                        w_state_nxt   = WRITE_DATA;
                        w_cnt_nxt     = '0;
                        w_sda_out_nxt = LVL_NACK;
                    end
                end
                READ_DATA: begin
                    if (w_scl_rise && r_cnt < BITS_PER_BYTE) begin
                        w_cnt_nxt = r_cnt + 4'd1;
                    end else if (w_scl_fall) begin
                        if (r_cnt == BITS_PER_BYTE) begin
                            w_state_nxt   = READ_ACK;
                            w_cnt_nxt     = '0;
                            w_sda_out_nxt = LVL_NACK;
                            w_ptr_nxt     = w_ptr_inc;
                        end else begin
                            w_shift_nxt   = {r_shift[6:0], 1'b0};
                            w_sda_out_nxt = r_shift[6];
                        end
                    end
                end
                READ_ACK: begin
                    if (w_scl_rise) begin
                        w_mack_nxt = w_sda_lvl;
                    end else if (w_scl_fall) begin
                        w_cnt_nxt = '0;
                        if (r_mack == LVL_NACK) begin
                            w_state_nxt   = IGNORE;
                            w_sda_out_nxt = LVL_NACK;
                            w_busy_nxt    = 1'b0;
                        end else begin
                            w_state_nxt   = READ_DATA;
                            w_shift_nxt   = w_rd_byte;
                            w_sda_out_nxt = w_rd_byte[7];
                        end
                    end
                end
                default: begin
                    w_state_nxt   = IDLE;
                    w_sda_out_nxt = LVL_NACK;
                end
            endcase
        end
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_ptr     <= '0;
            r_sda_out <= LVL_NACK;
            r_busy    <= 1'b0;
            r_rw      <= 1'b0;
            r_mack    <= LVL_NACK;
            r_strobe  <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_ptr     <= w_ptr_nxt;
            r_sda_out <= w_sda_out_nxt;
            r_busy    <= w_busy_nxt;
            r_rw      <= w_rw_nxt;
            r_mack    <= w_mack_nxt;
            r_strobe  <= w_wr_en;
            if (w_wr_en) begin
                r_wr_addr <= r_ptr;
                r_wr_data <= w_byte_in;
            end
        end
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            for (int i = 0; i < REG_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[r_ptr] <= w_byte_in;
        end
    end

    // Open drain: only ever pull low or release.
    assign i2c_serial_data   = (r_sda_out == 1'b0) ? 1'b0 : 1'bz;
    assign reg_write_strobe  = r_strobe;
    assign reg_write_address = r_wr_addr;
    assign reg_write_data    = r_wr_data;
    assign busy              = r_busy;

endmodule

// File: tb/tb_i2c_target_regs.sv
`timescale 1ns/1ps
// Directed bus-master bench for i2c_target_regs: 100 kHz SCL bit-banged against a pulled-up SDA.
module tb_i2c_target_regs;

    localparam time Q = 2500ns;

    logic       clock_25 = 1'b0;
    logic       reset    = 1'b1;
    logic       r_m_scl  = 1'b1;
    logic       r_m_sda  = 1'b1;
    wire        sda;
    logic       reg_write_strobe;
    logic [7:0] reg_write_address;
    logic [7:0] reg_write_data;
    logic       busy;

    int n_assert  = 0;
    int n_fail    = 0;
    int n_strobe  = 0;
    int n_tgt_low = 0;
    int n_busy    = 0;
    logic [7:0] s_addr [0:63];
    logic [7:0] s_data [0:63];

    pullup (sda);
    assign sda = r_m_sda ? 1'bz : 1'b0;

    i2c_target_regs #(
        .TARGET_ADDR  (7'h39),
        .FILTER_DEPTH (3),
        .REG_DEPTH    (256)
    ) dut (
        .clock_25          (clock_25),
        .reset             (reset),
        .i2c_serial_clock  (r_m_scl),
        .i2c_serial_data   (sda),
        .reg_write_strobe  (reg_write_strobe),
        .reg_write_address (reg_write_address),
        .reg_write_data    (reg_write_data),
        .busy              (busy)
    );

    always #20ns clock_25 = ~clock_25;

    // Bus monitor: logs every strobe cycle, target-driven lows and busy cycles.
    always @(negedge clock_25) begin
        if (reg_write_strobe === 1'b1) begin
            if (n_strobe < 64) begin
                s_addr[n_strobe[5:0]] = reg_write_address;
                s_data[n_strobe[5:0]] = reg_write_data;
            end
            n_strobe++;
        end
        if (sda === 1'b0 && r_m_sda) n_tgt_low++;
        if (busy === 1'b1) n_busy++;
    end

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_strobe(input string tag, input int idx, input logic [7:0] a, input logic [7:0] d);
        logic [7:0] ga, gd;
        ga = (idx < 64) ? s_addr[idx[5:0]] : 8'hxx;
        gd = (idx < 64) ? s_data[idx[5:0]] : 8'hxx;
        chk_eq({tag, "_addr"}, {24'h0, ga}, {24'h0, a});
        chk_eq({tag, "_data"}, {24'h0, gd}, {24'h0, d});
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clock_25);
    endtask

    task automatic bus_start();
        r_m_sda = 1'b1; #Q;
        r_m_scl = 1'b1; #Q;
        r_m_sda = 1'b0; #Q;
        r_m_scl = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        r_m_sda = 1'b0; #Q;
        r_m_scl = 1'b1; #Q;
        r_m_sda = 1'b1; #Q;
    endtask

    task automatic put_bit(input logic b);
        r_m_sda = b; #Q;
        r_m_scl = 1'b1; #(2 * Q);
        r_m_scl = 1'b0; #Q;
    endtask

    task automatic get_bit(output logic b);
        r_m_sda = 1'b1; #Q;
        r_m_scl = 1'b1; #Q;
        b = sda; #Q;
        r_m_scl = 1'b0; #Q;
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) put_bit(v[i]);
        get_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] v, input logic nack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            get_bit(b);
            v[i] = b;
        end
        put_bit(nack);
    endtask

    initial begin
        logic       a;
        logic [7:0] rb0, rb1;
        int         s0, t0, b0;

        // Reset state
        wait_clks(10);
        @(negedge clock_25);
        chk_eq("rst_busy",   {31'h0, busy}, 32'h0);
        chk_eq("rst_strobe", {31'h0, reg_write_strobe}, 32'h0);
        chk_eq("rst_waddr",  {24'h0, reg_write_address}, 32'h0);
        chk_eq("rst_wdata",  {24'h0, reg_write_data}, 32'h0);
        chk_eq("rst_sda",    {31'h0, sda}, 32'h1);
        @(posedge clock_25); #1 reset = 1'b0;
        wait_clks(20);

        // 1: single register write
        s0 = n_strobe;
        bus_start();
        write_byte(8'h72, a); chk_eq("t1_ack_addr", {31'h0, a}, 32'h0);
        chk_eq("t1_busy_mid", {31'h0, busy}, 32'h1);
        write_byte(8'h41, a); chk_eq("t1_ack_ptr", {31'h0, a}, 32'h0);
        write_byte(8'h10, a); chk_eq("t1_ack_data", {31'h0, a}, 32'h0);
        bus_stop();
        wait_clks(20);
        chk_eq("t1_nstrobe", n_strobe - s0, 1);
        chk_strobe("t1_wr", s0, 8'h41, 8'h10);
        chk_eq("t1_busy_end", {31'h0, busy}, 32'h0);

        // 2: two-byte burst write
        s0 = n_strobe;
        bus_start();
        write_byte(8'h72, a); chk_eq("t2_ack_addr", {31'h0, a}, 32'h0);
        write_byte(8'h01, a); chk_eq("t2_ack_ptr", {31'h0, a}, 32'h0);
        write_byte(8'h00, a); chk_eq("t2_ack_d0", {31'h0, a}, 32'h0);
        write_byte(8'h18, a); chk_eq("t2_ack_d1", {31'h0, a}, 32'h0);
        bus_stop();
        wait_clks(20);
        chk_eq("t2_nstrobe", n_strobe - s0, 2);
        chk_strobe("t2_wr0", s0, 8'h01, 8'h00);
        chk_strobe("t2_wr1", s0 + 1, 8'h02, 8'h18);

        // 3: foreign address is ignored
        s0 = n_strobe; t0 = n_tgt_low; b0 = n_busy;
        bus_start();
        write_byte(8'h74, a); chk_eq("t3_nack_addr", {31'h0, a}, 32'h1);
        write_byte(8'hAA, a); chk_eq("t3_nack_data", {31'h0, a}, 32'h1);
        bus_stop();
        wait_clks(20);
        chk_eq("t3_tgt_low", n_tgt_low - t0, 0);
        chk_eq("t3_nstrobe", n_strobe - s0, 0);
        chk_eq("t3_busy_cycles", n_busy - b0, 0);

        // 4: preload, then pointer write + repeated START + two-byte read
        s0 = n_strobe;
        bus_start();
        write_byte(8'h72, a);
        write_byte(8'hAF, a);
        write_byte(8'h16, a);
        write_byte(8'h5A, a);
        bus_stop();
        wait_clks(20);
        chk_eq("t4_pre_nstrobe", n_strobe - s0, 2);
        bus_start();
        write_byte(8'h72, a); chk_eq("t4_ack_waddr", {31'h0, a}, 32'h0);
        write_byte(8'hAF, a); chk_eq("t4_ack_ptr", {31'h0, a}, 32'h0);
        bus_start();
        write_byte(8'h73, a); chk_eq("t4_ack_raddr", {31'h0, a}, 32'h0);
        read_byte(rb0, 1'b0);
        read_byte(rb1, 1'b1);
        t0 = n_tgt_low;
        #(4 * Q);
        chk_eq("t4_rd0", {24'h0, rb0}, 32'h16);
        chk_eq("t4_rd1", {24'h0, rb1}, 32'h5A);
        chk_eq("t4_sda_after_nack", {31'h0, sda}, 32'h1);
        chk_eq("t4_tgt_low_after_nack", n_tgt_low - t0, 0);
        chk_eq("t4_busy_after_nack", {31'h0, busy}, 32'h0);
        bus_stop();
        wait_clks(20);

        // 5: pointer wraps from 8'hFF to 8'h00
        s0 = n_strobe;
        bus_start();
        write_byte(8'h72, a);
        write_byte(8'hFF, a);
        write_byte(8'h11, a); chk_eq("t5_ack_d0", {31'h0, a}, 32'h0);
        write_byte(8'h22, a); chk_eq("t5_ack_d1", {31'h0, a}, 32'h0);
        bus_stop();
        wait_clks(20);
        chk_eq("t5_nstrobe", n_strobe - s0, 2);
        chk_strobe("t5_wr0", s0, 8'hFF, 8'h11);
        chk_strobe("t5_wr1", s0 + 1, 8'h00, 8'h22);

        // 6: reset during the 5th data bit, then a clean write
        s0 = n_strobe;
        bus_start();
        write_byte(8'h72, a);
        write_byte(8'h60, a);
        put_bit(1'b0); put_bit(1'b1); put_bit(1'b0); put_bit(1'b1);
        r_m_sda = 1'b1; #Q;
        r_m_scl = 1'b1; #Q;
        chk_eq("t6_busy_pre_rst", {31'h0, busy}, 32'h1);
        @(posedge clock_25); #1 reset = 1'b1;
        @(posedge clock_25); #1;
        chk_eq("t6_sda_rel", {31'h0, sda}, 32'h1);
        chk_eq("t6_busy_rst", {31'h0, busy}, 32'h0);
        wait_clks(4); #1 reset = 1'b0;
        #Q r_m_scl = 1'b0; #Q;
        bus_stop();
        wait_clks(20);
        chk_eq("t6_nstrobe_abort", n_strobe - s0, 0);
        bus_start();
        write_byte(8'h72, a); chk_eq("t6_ack_addr", {31'h0, a}, 32'h0);
        write_byte(8'h41, a); chk_eq("t6_ack_ptr", {31'h0, a}, 32'h0);
        write_byte(8'h10, a); chk_eq("t6_ack_data", {31'h0, a}, 32'h0);
        bus_stop();
        wait_clks(20);
        chk_eq("t6_nstrobe", n_strobe - s0, 1);
        chk_strobe("t6_wr", s0, 8'h41, 8'h10);
        chk_eq("t6_busy_end", {31'h0, busy}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
